pll_ctrl: RTL

PLL_CTRL -- requirements
Module: pll_ctrl

---
 rtl/pll_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pll_ctrl.sv
// PLL bring-up sequencer: resets the PLL, waits for and qualifies lock, then releases
// the CPU pipeline and paces it with a divided or single-stepped clock enable.
module pll_ctrl #(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 1024,
    parameter int STABLE_CYCLES = 8
) (
    input  logic       inclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic [7:0] div,
    input  logic       step_mode,
    input  logic       step_req,
    input  logic       retry,
    output logic       pll_areset,
    output logic       cpu_rst_n,
    output logic       clk_en,
    output logic       fault,
    output logic [2:0] state,
    output logic [3:0] relock_cnt
);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    // One shared phase counter, sized for the longest of the three intervals.
    localparam int CNT_MAX_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       div_cnt;
    logic             step_prev;
    logic             step_pulse;
    logic             in_run;

    assign in_run = (st == RUN);

    always_ff @(posedge inclk) begin
        if (!rst_n) begin
            st         <= PLL_RST;
            cnt        <= '0;
            relock_cnt <= '0;
        end else begin
            case (st)
                PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        st  <= WAIT_LOCK;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // Lock is checked before the timeout so a late lock still wins.
                WAIT_LOCK: begin
                    if (pll_locked) begin
                        st  <= STABLE;
                        cnt <= '0;
                    end else if (cnt == LOCK_LAST) begin
                        st  <= FAULT;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE: begin
                    if (!pll_locked) begin
                        st  <= WAIT_LOCK;
                        cnt <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        st  <= RUN;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!pll_locked) begin
                        st  <= PLL_RST;
                        cnt <= '0;
                        if (relock_cnt != 4'd15) begin
                            relock_cnt <= relock_cnt + 4'd1;
                        end
                    end
                end
                FAULT: begin
                    if (retry) begin
                        st  <= PLL_RST;
                        cnt <= '0;
                    end
                end
                default: begin
                    st  <= PLL_RST;
                    cnt <= '0;
                end
            endcase
        end
    end

    // div_cnt idles at zero outside free-running RUN so the first enabled cycle fires at once.
    always_ff @(posedge inclk) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            step_prev  <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            step_prev  <= step_req;
            step_pulse <= in_run && step_mode && step_req && !step_prev;
            if (!in_run || step_mode) begin
                div_cnt <= '0;
            end else if (div_cnt == 8'd0) begin
                div_cnt <= div;
            end else begin
                div_cnt <= div_cnt - 8'd1;
            end
        end
    end

    assign clk_en     = in_run && ((!step_mode && (div_cnt == 8'd0)) || step_pulse);
    assign pll_areset = (st == PLL_RST);
    assign cpu_rst_n  = in_run;
    assign fault      = (st == FAULT);
    assign state      = st;

endmodule
